// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I controller: FSM states,
// opcodes, ALUControl codes, datapath select codes and branch funct3 values.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_UPPER    = 4'd13,
        S_TRAP     = 4'd14
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'd0,
        ALUOP_BRANCH = 2'd1,
        ALUOP_FUNCT  = 2'd2
    } aluop_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Immediate format implied by the opcode; R-type and unknown opcodes fall back to I.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        logic [2:0] imm;
        case (op)
            OP_STORE:        imm = IMM_S;
            OP_BRANCH:       imm = IMM_B;
            OP_LUI, OP_AUIPC: imm = IMM_U;
            OP_JAL:          imm = IMM_J;
            default:         imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU decoder: maps the ALU operation class, funct3, funct7b5 and op[5] to an
// ALUControl code, plus branch validity and the zero polarity that means "taken".
module multicycle_ctrl_alu_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [3:0] alu_ctrl,
    output logic       taken_on_zero,
    output logic       br_valid
);

    // Operation and branch polarity decode.
    always_comb begin
        alu_ctrl      = ALU_ADD;
        taken_on_zero = 1'b0;
        br_valid      = 1'b0;
        case (alu_op)
            ALUOP_BRANCH: begin
                case (funct3)
                    F3_BEQ:  begin alu_ctrl = ALU_SUB;  taken_on_zero = 1'b1; br_valid = 1'b1; end
                    F3_BNE:  begin alu_ctrl = ALU_SUB;  taken_on_zero = 1'b0; br_valid = 1'b1; end
                    F3_BLT:  begin alu_ctrl = ALU_SLT;  taken_on_zero = 1'b0; br_valid = 1'b1; end
                    F3_BGE:  begin alu_ctrl = ALU_SLT;  taken_on_zero = 1'b1; br_valid = 1'b1; end
                    F3_BLTU: begin alu_ctrl = ALU_SLTU; taken_on_zero = 1'b0; br_valid = 1'b1; end
                    F3_BGEU: begin alu_ctrl = ALU_SLTU; taken_on_zero = 1'b1; br_valid = 1'b1; end
                    default: begin alu_ctrl = ALU_ADD;  taken_on_zero = 1'b0; br_valid = 1'b0; end
                endcase
            end
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        // Only register-register ops use funct7b5 to select SUB; ADDI has no such bit.
                        if (op5 && funct7b5) begin
                            alu_ctrl = ALU_SUB;
                        end else begin
                            alu_ctrl = ALU_ADD;
                        end
                    end
                    3'b001: alu_ctrl = ALU_SLL;
                    3'b010: alu_ctrl = ALU_SLT;
                    3'b011: alu_ctrl = ALU_SLTU;
                    3'b100: alu_ctrl = ALU_XOR;
                    3'b101: begin
                        if (funct7b5) begin
                            alu_ctrl = ALU_SRA;
                        end else begin
                            alu_ctrl = ALU_SRL;
                        end
                    end
                    3'b110: alu_ctrl = ALU_OR;
                    3'b111: alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with memory wait-state timeout and sticky traps.
// Optional performance counters are compiled in with `define CTRL_PERF_EN.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 32'd255
`ifdef CTRL_PERF_EN
    ,
    parameter int unsigned PERF_W = 32'd32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       illegal,
    output logic       bus_err
`ifdef CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt
`endif
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 32'd1) ? $clog2(TIMEOUT_CYC + 32'd1) : 32'd1;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      cnt_inc_s;
    logic             mem_wait_s;
    logic             timeout_s;
    logic [1:0]       alu_op_s;
    logic [3:0]       alu_ctrl_s;
    logic             taken_on_zero_s;
    logic             br_valid_s;

    multicycle_ctrl_alu_dec u_alu_dec (
        .alu_op        (alu_op_s),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .op5           (op[5]),
        .alu_ctrl      (alu_ctrl_s),
        .taken_on_zero (taken_on_zero_s),
        .br_valid      (br_valid_s)
    );

    assign ALUControl = alu_ctrl_s;
    assign illegal    = illegal_q;
    assign bus_err    = bus_err_q;

    // ALU operation class per state.
    always_comb begin
        case (state_q)
            S_EXECR, S_EXECI: alu_op_s = ALUOP_FUNCT;
            S_BRANCH:         alu_op_s = ALUOP_BRANCH;
            default:          alu_op_s = ALUOP_ADD;
        endcase
    end

    // Wait-state counter; the limit fires on the TIMEOUT_CYC-th consecutive unready cycle.
    always_comb begin
        mem_wait_s = ((state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE))
                     && !mem_ready;
        cnt_inc_s  = {{(32 - CNT_W){1'b0}}, cnt_q} + 32'd1;
        timeout_s  = 1'b0;
        cnt_d      = {CNT_W{1'b0}};
        if (mem_wait_s && (TIMEOUT_CYC != 32'd0)) begin
            if (cnt_inc_s == TIMEOUT_CYC) begin
                timeout_s = 1'b1;
            end else begin
                cnt_d = cnt_inc_s[CNT_W-1:0];
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ImmSrc    = imm_src_of(op);
        case (state_q)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_s) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR1;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                    default: begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                if (op[5]) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_s) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                ResultSrc = RES_READDATA;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_s) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                ResultSrc = RES_ALUOUT;
                if (br_valid_s) begin
                    PCWrite = (zero == taken_on_zero_s);
                    state_d = S_FETCH;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_JAL, S_JALR2: begin
                // Target already sits in ALUOut; the ALU meanwhile forms OldPC+4 for the link.
                PCWrite   = 1'b1;
                ResultSrc = RES_ALUOUT;
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                state_d   = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = S_JALR2;
            end
            S_UPPER: begin
                if (op[5]) begin
                    ALUSrcA = SRCA_ZERO;
                end else begin
                    ALUSrcA = SRCA_OLDPC;
                end
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
                state_d = S_ALUWB;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    // State, wait counter and sticky trap flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= {CNT_W{1'b0}};
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef CTRL_PERF_EN
    logic [PERF_W-1:0] cycle_q, cycle_d;
    logic [PERF_W-1:0] instret_q, instret_d;

    // Cycle count freezes in TRAP; an instruction retires on each return to FETCH.
    always_comb begin
        if (state_q != S_TRAP) begin
            cycle_d = cycle_q + {{(PERF_W - 1){1'b0}}, 1'b1};
        end else begin
            cycle_d = cycle_q;
        end
        if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
            instret_d = instret_q + {{(PERF_W - 1){1'b0}}, 1'b1};
        end else begin
            instret_d = instret_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= {PERF_W{1'b0}};
            instret_q <= {PERF_W{1'b0}};
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized
// instruction streams checked against a per-instruction phase model.
module tb_multicycle_ctrl;

    localparam int unsigned TO = 4;
    localparam int PH_FETCH = 0, PH_DECODE = 1, PH_ADR = 2, PH_RD = 3, PH_RDWB = 4,
                   PH_WR = 5, PH_EXR = 6, PH_EXI = 7, PH_WB = 8, PH_BR = 9,
                   PH_JAL = 10, PH_JR1 = 11, PH_JR2 = 12, PH_UP = 13, PH_TRAP = 14;

    logic clk = 1'b0;
    logic reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic funct7b5, zero, mem_ready;
    logic MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic illegal, bus_err;
`ifdef CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
    int unsigned exp_cyc, exp_ret;
`endif

    int checks = 0;
    int failures = 0;
    logic exp_ill, exp_berr;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic cur_f7;
    logic [18:0] obs_vec;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .MemReq(MemReq), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal(illegal), .bus_err(bus_err)
`ifdef CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    assign obs_vec = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                      ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011:             return 3'b001;
            7'b1100011:             return 3'b010;
            7'b0110111, 7'b0010111: return 3'b011;
            7'b1101111:             return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o == 7'b0110011 && f7) ? 4'd1 : 4'd0;
            3'd1:    return 4'd7;
            3'd2:    return 4'd5;
            3'd3:    return 4'd6;
            3'd4:    return 4'd4;
            3'd5:    return f7 ? 4'd9 : 4'd8;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic [3:0] br_alu(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd1: return 4'd1;
            3'd4, 3'd5: return 4'd5;
            3'd6, 3'd7: return 4'd6;
            default:    return 4'd0;
        endcase
    endfunction

    // Expected control word {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,Res,A,B,Imm,ALU}.
    function automatic logic [18:0] exp_vec(input int ph, input logic rdy, input logic tk);
        logic mreq, mw, adr, irw, pcw, rw;
        logic [1:0] res, sa, sb;
        logic [2:0] imm;
        logic [3:0] alu;
        {mreq, mw, adr, irw, pcw, rw} = 6'b0;
        res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 4'd0;
        imm = imm_of(cur_op);
        case (ph)
            PH_FETCH:  begin mreq = 1'b1; irw = rdy; pcw = rdy; res = 2'b10; sb = 2'b10; end
            PH_DECODE: begin sa = 2'b01; sb = 2'b01; end
            PH_ADR:    begin sa = 2'b10; sb = 2'b01; end
            PH_RD:     begin mreq = 1'b1; adr = 1'b1; end
            PH_RDWB:   begin res = 2'b01; rw = 1'b1; end
            PH_WR:     begin mreq = 1'b1; mw = 1'b1; adr = 1'b1; end
            PH_EXR:    begin sa = 2'b10; alu = alu_of(cur_op, cur_f3, cur_f7); end
            PH_EXI:    begin sa = 2'b10; sb = 2'b01; alu = alu_of(cur_op, cur_f3, cur_f7); end
            PH_WB:     begin rw = 1'b1; end
            PH_BR:     begin sa = 2'b10; pcw = tk; alu = br_alu(cur_f3); end
            PH_JAL, PH_JR2: begin pcw = 1'b1; sa = 2'b01; sb = 2'b10; end
            PH_JR1:    begin sa = 2'b10; sb = 2'b01; end
            PH_UP:     begin sa = cur_op[5] ? 2'b11 : 2'b01; sb = 2'b01; imm = 3'b011; end
            default:   begin end
        endcase
        return {mreq, mw, adr, irw, pcw, rw, res, sa, sb, imm, alu};
    endfunction

    // One clock: drive inputs, compare at the falling edge, advance past the rising edge.
    task automatic cyc(input int ph, input logic rdy, input logic z, input logic tk);
        mem_ready = rdy;
        zero      = z;
        @(negedge clk);
        check($sformatf("ctrl_ph%0d", ph), {13'd0, obs_vec}, {13'd0, exp_vec(ph, rdy, tk)});
        check("flags", {30'd0, illegal, bus_err}, {30'd0, exp_ill, exp_berr});
`ifdef CTRL_PERF_EN
        if (ph != PH_TRAP) exp_cyc++;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        zero = 1'b0;
        exp_ill = 1'b0;
        exp_berr = 1'b0;
        #1;
        check("rst_ctrl", {13'd0, obs_vec}, {13'd0, exp_vec(PH_FETCH, 1'b0, 1'b0)});
        check("rst_flags", {30'd0, illegal, bus_err}, 32'd0);
`ifdef CTRL_PERF_EN
        check("rst_cycle", cycle_cnt, 32'd0);
        check("rst_instret", instret_cnt, 32'd0);
        exp_cyc = 0;
        exp_ret = 0;
`endif
        #1 reset = 1'b0;
        #1;
        check("rel_ctrl", {13'd0, obs_vec}, {13'd0, exp_vec(PH_FETCH, 1'b0, 1'b0)});
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        cur_op = o; cur_f3 = f3; cur_f7 = f7;
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    // Whole instruction: fw/mw are unready cycles before the fetch and data accesses complete.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int fw, input int mw, input logic [31:0] a, input logic [31:0] b);
        logic z, tk;
        set_instr(o, f3, f7);
        for (int i = 0; i < fw; i++) cyc(PH_FETCH, 1'b0, 1'b0, 1'b0);
        cyc(PH_FETCH, 1'b1, 1'b0, 1'b0);
        cyc(PH_DECODE, 1'b0, 1'b0, 1'b0);
        case (o)
            7'b0000011: begin
                cyc(PH_ADR, 1'b0, 1'b0, 1'b0);
                for (int i = 0; i < mw; i++) cyc(PH_RD, 1'b0, 1'b0, 1'b0);
                cyc(PH_RD, 1'b1, 1'b0, 1'b0);
                cyc(PH_RDWB, 1'b0, 1'b0, 1'b0);
            end
            7'b0100011: begin
                cyc(PH_ADR, 1'b0, 1'b0, 1'b0);
                for (int i = 0; i < mw; i++) cyc(PH_WR, 1'b0, 1'b0, 1'b0);
                cyc(PH_WR, 1'b1, 1'b0, 1'b0);
            end
            7'b0110011: begin cyc(PH_EXR, 1'b0, 1'b0, 1'b0); cyc(PH_WB, 1'b0, 1'b0, 1'b0); end
            7'b0010011: begin cyc(PH_EXI, 1'b0, 1'b0, 1'b0); cyc(PH_WB, 1'b0, 1'b0, 1'b0); end
            7'b1100011: begin
                // zero is what the ALU would produce; tk is the architectural outcome.
                case (f3)
                    3'b000:  begin z = (a == b); tk = (a == b); end
                    3'b001:  begin z = (a == b); tk = (a != b); end
                    3'b100:  begin z = !($signed(a) < $signed(b)); tk = ($signed(a) < $signed(b)); end
                    3'b101:  begin z = !($signed(a) < $signed(b)); tk = ($signed(a) >= $signed(b)); end
                    3'b110:  begin z = !(a < b); tk = (a < b); end
                    3'b111:  begin z = !(a < b); tk = (a >= b); end
                    default: begin z = a[0]; tk = 1'b0; end
                endcase
                cyc(PH_BR, 1'b0, z, tk);
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    exp_ill = 1'b1;
                    for (int i = 0; i < 3; i++) cyc(PH_TRAP, 1'b1, 1'b1, 1'b0);
                end
            end
            7'b1101111: begin cyc(PH_JAL, 1'b0, 1'b0, 1'b0); cyc(PH_WB, 1'b0, 1'b0, 1'b0); end
            7'b1100111: begin
                cyc(PH_JR1, 1'b0, 1'b0, 1'b0);
                cyc(PH_JR2, 1'b0, 1'b0, 1'b0);
                cyc(PH_WB, 1'b0, 1'b0, 1'b0);
            end
            7'b0110111, 7'b0010111: begin cyc(PH_UP, 1'b0, 1'b0, 1'b0); cyc(PH_WB, 1'b0, 1'b0, 1'b0); end
            default: begin
                exp_ill = 1'b1;
                for (int i = 0; i < 3; i++) cyc(PH_TRAP, 1'b1, 1'b1, 1'b0);
            end
        endcase
`ifdef CTRL_PERF_EN
        if (!exp_ill) exp_ret++;
`endif
    endtask

    initial begin
        logic [6:0] ops [9];
        logic [2:0] brf3 [6];
        logic [6:0] o;
        logic [2:0] f3;
        logic [31:0] a, b;
        ops  = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        brf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        do_reset();

        // add x3,x1,x2 then lw with three wait-states in MEMREAD
        run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, 32'd0, 32'd0);
        run_instr(7'b0000011, 3'b010, 1'b0, 0, 3, 32'd0, 32'd0);
        // beq taken, beq not taken, bge taken
        run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 32'd7, 32'd7);
        run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 32'd7, 32'd9);
        run_instr(7'b1100011, 3'b101, 1'b0, 0, 0, 32'd9, 32'd7);

        for (int n = 0; n < 40; n++) begin
            o  = ops[$urandom_range(0, 8)];
            f3 = (o == 7'b1100011) ? brf3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 1) ? a : $urandom;
            run_instr(o, f3, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      $urandom_range(0, 2), a, b);
        end
`ifdef CTRL_PERF_EN
        check("perf_cycle", cycle_cnt, exp_cyc);
        check("perf_instret", instret_cnt, exp_ret);
`endif

        // Ready on the limit cycle completes the store without error
        run_instr(7'b0100011, 3'b010, 1'b0, 0, TO - 1, 32'd0, 32'd0);

        // Store that never completes: bus_err after TO unready cycles
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc(PH_FETCH, 1'b1, 1'b0, 1'b0);
        cyc(PH_DECODE, 1'b0, 1'b0, 1'b0);
        cyc(PH_ADR, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < TO; i++) cyc(PH_WR, 1'b0, 1'b0, 1'b0);
        exp_berr = 1'b1;
        for (int i = 0; i < 3; i++) cyc(PH_TRAP, 1'b1, 1'b0, 1'b0);
        do_reset();

        // Fetch timeout
        for (int i = 0; i < TO; i++) cyc(PH_FETCH, 1'b0, 1'b0, 1'b0);
        exp_berr = 1'b1;
        cyc(PH_TRAP, 1'b1, 1'b0, 1'b0);
        do_reset();

        // Illegal opcode 0x7F, then illegal branch funct3
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 32'd0, 32'd0);
        do_reset();
        run_instr(7'b1100011, 3'b010, 1'b0, 1, 0, 32'd1, 32'd2);
        do_reset();

        // Asynchronous reset while a store is waiting
        set_instr(7'b0100011, 3'b000, 1'b0);
        cyc(PH_FETCH, 1'b1, 1'b0, 1'b0);
        cyc(PH_DECODE, 1'b0, 1'b0, 1'b0);
        cyc(PH_ADR, 1'b0, 1'b0, 1'b0);
        cyc(PH_WR, 1'b0, 1'b0, 1'b0);
        check("mw_before_rst", {31'd0, MemWrite}, 32'd1);
        do_reset();
        check("mw_after_rst", {31'd0, MemWrite}, 32'd0);
        run_instr(7'b0010011, 3'b101, 1'b1, 0, 0, 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore/Mealy FSM that sequences a multicycle RV32I datapath sharing one ALU and one memory port between instruction fetch and data access. Drives mux selects, ALUControl, and register, PC and IR enables from the instruction fields plus zero. Handles memory wait-states with a ready handshake and a timeout. Traps on illegal opcodes and on bus timeouts.

Parameters:
TIMEOUT_CYC, 255, maximum cycles in a memory state without mem_ready before bus_err; 0 disables the timeout.
PERF_W, 32, width of the performance counters (used only with CTRL_PERF_EN).

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; state goes to FETCH immediately
op  input  7  Instr[6:0] from the IR
funct3  input  3  Instr[14:12]
funct7b5  input  1  Instr[30]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
MemReq  output  1  memory access request
MemWrite  output  1  store strobe
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
IRWrite  output  1  latch instruction and OldPC
PCWrite  output  1  PC load enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  result select: 00=ALUOut, 01=ReadData, 10=ALUResult
ALUSrcA  output  2  ALU A select: 00=PC, 01=OldPC, 10=rs1 reg, 11=zero
ALUSrcB  output  2  ALU B select: 00=rs2 reg, 01=ImmExt, 10=constant 4
ImmSrc  output  3  immediate type: 000=I, 001=S, 010=B, 011=U, 100=J
ALUControl  output  4  ALU operation code
illegal  output  1  sticky trap flag: bad opcode or funct3
bus_err  output  1  sticky trap flag: memory timeout

Behaviour:
- ALUControl codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
- Defaults in every state: all enables 0, selects 00, ADD; ImmSrc is decoded from op in every state.
- Reset: state=FETCH, timeout counter=0, illegal=0, bus_err=0. Outputs immediately take FETCH values, so MemWrite and RegWrite drop asynchronously.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. IRWrite=PCWrite=mem_ready. On mem_ready go to DECODE, otherwise hold.
- DECODE: ALUSrcA=01, ALUSrcB=01, ADD; computes the branch/JAL target into ALUOut. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR1
  - 0110111 or 0010111 -> UPPER
  - any other -> TRAP with illegal set
- MEMADR: ALUSrcA=10, ALUSrcB=01, ADD. Go to MEMREAD if op[5]=0, otherwise MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1; on mem_ready go to MEMWB. MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1; on mem_ready go to FETCH. MemWrite stays high while waiting.
- EXECR: ALUSrcA=10, ALUSrcB=00. EXECI: ALUSrcA=10, ALUSrcB=01. Both go to ALUWB.
- ALU decode (EXECR/EXECI), by funct3:
  - 000: SUB if R-type and funct7b5, otherwise ADD
  - 101: SRA if funct7b5, otherwise SRL
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00, then FETCH. PCWrite=taken (Mealy on zero). By funct3:
  - beq: SUB, taken if zero; bne: SUB, taken if !zero
  - blt: SLT, taken if !zero; bge: SLT, taken if zero
  - bltu: SLTU, taken if !zero; bgeu: SLTU, taken if zero
  - 010/011 -> TRAP with illegal set
- JAL: PCWrite=1, ResultSrc=00, ALUSrcA=01, ALUSrcB=10; go to ALUWB, which writes OldPC+4.
- JALR1: ALUSrcA=10, ALUSrcB=01 (rs1+imm into ALUOut), then JALR2. JALR2: same controls as JAL, then ALUWB. The datapath clears bit 0 of the target.
- UPPER: ALUSrcA=11 when op[5]=1 (LUI), 01 otherwise (AUIPC); ALUSrcB=01, ImmSrc=011; go to ALUWB.
- TRAP: all enables 0; state held until reset.
- Timeout counter:
  - Counts cycles in FETCH, MEMREAD or MEMWRITE with mem_ready=0; clears on mem_ready or on leaving the state.
  - When it reaches TIMEOUT_CYC with mem_ready still 0: bus_err=1, go to TRAP.
  - mem_ready in the same cycle as the limit wins (access completes, no error).
- Latency with mem_ready tied 1: loads 5 cycles; ALU ops, JAL, LUI/AUIPC 4; JALR 5; stores 4; branches 3.

Optional Feature:
CTRL_PERF_EN:
- Defined: adds outputs cycle_cnt[PERF_W-1:0] and instret_cnt[PERF_W-1:0], both reset to 0.
  - cycle_cnt increments every cycle except in TRAP.
  - instret_cnt increments on every transition into FETCH from a non-FETCH state.
  - Both wrap modulo 2^PERF_W.
- Undefined: neither port nor the counter logic exists.

Decomposition:
- ctrl_pkg holds: the state enum, opcode constants, ALUControl codes, ResultSrc/ALUSrcA/ALUSrcB/ImmSrc codes, and branch funct3 constants.
- One sub-module, alu_dec: combinational mapping of ALUOp class, funct3, funct7b5 and op[5] to ALUControl and branch-taken polarity.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 -> states FETCH,DECODE,EXECR,ALUWB; ALUControl=0000 in EXECR; RegWrite=1 only in cycle 4.
- lw (0x0000A183) with mem_ready low 3 cycles in MEMREAD -> MemReq/AdrSrc=1 held for 4 cycles; MEMWB follows the ready cycle; bus_err stays 0.
- beq with zero=1, then zero=0 -> PCWrite=1 in BRANCH for the first, 0 for the second; bge with zero=1 -> taken.
- Illegal op=0x7F -> DECODE then TRAP; illegal=1; no PCWrite/RegWrite/MemReq afterwards until reset.
- TIMEOUT_CYC=4, store with mem_ready=0 -> bus_err=1 after 4 wait cycles, TRAP; ready arriving on cycle 4 instead -> no error.
- reset asserted mid-MEMWRITE -> MemWrite=0 in the same cycle without a clock edge; FETCH outputs on release; with CTRL_PERF_EN both counters read 0.
